// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter sequencer.
package counter_seq_pkg;

  localparam int unsigned DEF_WIDTH          = 3;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_COMPLETE,
    S_ERROR
  } seq_state_e;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with registered empty/full flags and a look-ahead empty flag.
module seq_cmd_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             empty_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  assign empty_next_c = (count_next == '0);
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Drives an external down-counter through load/arm/run/complete for each buffered command,
// with a watchdog that parks in ERROR until err_clr.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_count_to,
  output logic             cnt_count_en,
  input  logic             cnt_done,
  input  logic             err_clr,
  output logic             busy,
  output logic             seq_done,
  output logic [7:0]       done_count,
  output logic             timeout_err
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

  seq_state_e         state;
  seq_state_e         state_next;
  logic [TIMER_W-1:0] timer;
  logic               push_c;
  logic               pop_c;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_empty_next_c;
  logic [WIDTH-1:0]   fifo_head;

  assign cmd_ready = ~fifo_full;
  assign push_c    = cmd_valid & ~fifo_full;

  seq_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push_c),
    .data         (cmd_value),
    .pop          (pop_c),
    .head         (fifo_head),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .empty_next_c (fifo_empty_next_c)
  );

  // Next-state logic; the FIFO head is retired only when leaving COMPLETE or ERROR.
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    case (state)
      S_IDLE:     if (!fifo_empty) state_next = S_LOAD;
      S_LOAD:     state_next = S_ARM;
      S_ARM:      state_next = S_RUN;
      S_RUN: begin
        if (cnt_done)                                   state_next = S_COMPLETE;
        else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) state_next = S_ERROR;
      end
      S_COMPLETE: begin
        pop_c      = 1'b1;
        state_next = S_IDLE;
      end
      S_ERROR: begin
        if (err_clr) begin
          pop_c      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the current state exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      done_count   <= '0;
      cnt_load     <= 1'b0;
      cnt_count_to <= '0;
      cnt_count_en <= 1'b0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt_load     <= (state_next == S_LOAD);
      cnt_count_to <= (state_next == S_LOAD) ? fifo_head : '0;
      cnt_count_en <= (state_next == S_ARM) || (state_next == S_RUN);
      seq_done     <= (state_next == S_COMPLETE);
      timeout_err  <= (state_next == S_ERROR);
      busy         <= (state_next != S_IDLE) || !fifo_empty_next_c;
      if (state == S_COMPLETE) done_count <= done_count + 8'(1);
      if (state == S_LOAD) begin
        timer <= '0;
      end else if ((state == S_ARM || state == S_RUN) && timer != '1) begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural down-counter and a stuck-done stub.
module tb_counter_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_value;
  logic       cnt_load;
  logic [2:0] cnt_count_to;
  logic       cnt_count_en;
  logic       cnt_done;
  logic       err_clr;
  logic       busy;
  logic       seq_done;
  logic [7:0] done_count;
  logic       timeout_err;

  logic       stub_en;
  logic [2:0] ctr;
  logic       ctr_done;

  int n_vec = 0;
  int n_err = 0;
  int done_pulses = 0;
  int en_total = 0;
  logic [2:0] load_q[$];
  int t;
  int base_done;
  int base_load;
  int base_en;
  int n;

  counter_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_value    (cmd_value),
    .cnt_load     (cnt_load),
    .cnt_count_to (cnt_count_to),
    .cnt_count_en (cnt_count_en),
    .cnt_done     (cnt_done),
    .err_clr      (err_clr),
    .busy         (busy),
    .seq_done     (seq_done),
    .done_count   (done_count),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter: load wins, otherwise decrement toward zero.
  always @(posedge clk) begin
    if (!reset_n)                      ctr <= 3'd0;
    else if (cnt_load)                 ctr <= cnt_count_to;
    else if (cnt_count_en && ctr != 0) ctr <= ctr - 3'd1;
  end
  assign ctr_done = (ctr == 3'd0);
  assign cnt_done = stub_en ? 1'b0 : ctr_done;

  always @(posedge clk) begin
    if (cnt_load)     load_q.push_back(cnt_count_to);
    if (seq_done)     done_pulses <= done_pulses + 1;
    if (cnt_count_en) en_total <= en_total + 1;
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] v);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_value = v;
    while (!cmd_ready && w < 200) begin
      tick(1);
      w++;
    end
    if (w == 200) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done_pulses(input int base, input int cnt, input int budget, input string tag);
    int w;
    w = 0;
    while ((done_pulses - base) < cnt && w < budget) begin
      tick(1);
      w++;
    end
    check(tag, 32'(done_pulses - base), 32'(cnt));
  endtask

  task automatic cycles_to_done(output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (!seq_done && cyc < 40);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_value = 3'd0;
    err_clr   = 1'b0;
    stub_en   = 1'b0;

    // Reset held for two edges
    tick(2);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cnt_load", 32'(cnt_load), 32'd0);
    check("rst_cnt_en", 32'(cnt_count_en), 32'd0);
    check("rst_count_to", 32'(cnt_count_to), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single command 7: LOAD, ARM, 7 RUN cycles, COMPLETE -> seq_done 10 cycles after push
    base_load = load_q.size();
    push(3'd7);
    cycles_to_done(t);
    check("c7_latency", 32'(t), 32'd10);
    n = load_q.size();
    check("c7_load_pulses", 32'(n - base_load), 32'd1);
    check("c7_load_value", 32'(load_q[n-1]), 32'd7);
    tick(1);
    check("c7_seq_done_pulse", 32'(seq_done), 32'd0);
    check("c7_done_count", 32'(done_count), 32'd1);
    check("c7_busy", 32'(busy), 32'd0);

    // Three queued commands, with err_clr held high to show it is ignored outside ERROR
    err_clr   = 1'b1;
    base_load = load_q.size();
    base_done = done_pulses;
    push(3'd3);
    push(3'd5);
    push(3'd1);
    wait_done_pulses(base_done, 3, 100, "q3_done_pulses");
    err_clr = 1'b0;
    tick(1);
    n = load_q.size();
    check("q3_load_count", 32'(n - base_load), 32'd3);
    check("q3_load0", 32'(load_q[base_load]), 32'd3);
    check("q3_load1", 32'(load_q[base_load+1]), 32'd5);
    check("q3_load2", 32'(load_q[base_load+2]), 32'd1);
    check("q3_done_count", 32'(done_count), 32'd4);
    check("q3_busy", 32'(busy), 32'd0);

    // Value 0 takes the minimum LOAD/ARM/RUN/COMPLETE turnaround
    push(3'd0);
    cycles_to_done(t);
    check("c0_latency", 32'(t), 32'd4);
    tick(1);
    check("c0_done_count", 32'(done_count), 32'd5);

    // Stuck cnt_done: FIFO fills, watchdog fires after 16 ARM+RUN cycles
    stub_en = 1'b1;
    base_en = en_total;
    base_load = load_q.size();
    push(3'd1);
    push(3'd2);
    push(3'd3);
    push(3'd4);
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_value = 3'd5;
    tick(3);
    check("full_fifth_held", 32'(cmd_ready), 32'd0);
    t = 0;
    while (!timeout_err && t < 40) begin
      tick(1);
      t++;
    end
    check("to_err_high", 32'(timeout_err), 32'd1);
    check("to_en_cycles", 32'(en_total - base_en), 32'd16);
    check("to_cnt_en_low", 32'(cnt_count_en), 32'd0);
    check("to_cnt_load_low", 32'(cnt_load), 32'd0);
    tick(2);
    check("to_err_held", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    check("to_ready_still_low", 32'(cmd_ready), 32'd0);
    stub_en = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("clr_err_low", 32'(timeout_err), 32'd0);
    check("clr_done_count", 32'(done_count), 32'd5);
    check("clr_ready", 32'(cmd_ready), 32'd1);
    base_done = done_pulses;
    tick(1);
    cmd_valid = 1'b0;
    wait_done_pulses(base_done, 4, 150, "clr_done_pulses");
    tick(1);
    check("clr_done_count_after", 32'(done_count), 32'd9);
    n = load_q.size();
    check("clr_load_count", 32'(n - base_load), 32'd5);
    check("clr_load_first", 32'(load_q[base_load]), 32'd1);
    check("clr_load_second", 32'(load_q[base_load+1]), 32'd2);
    check("clr_load_last", 32'(load_q[n-1]), 32'd5);

    // Reset during RUN with two commands still queued
    push(3'd7);
    push(3'd6);
    push(3'd5);
    tick(1);
    check("mid_running", 32'(cnt_count_en), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_cnt_en", 32'(cnt_count_en), 32'd0);
    check("mid_rst_cnt_load", 32'(cnt_load), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done_count", 32'(done_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    base_load = load_q.size();
    tick(4);
    check("mid_rst_no_load", 32'(load_q.size() - base_load), 32'd0);
    check("mid_rst_still_idle", 32'(busy), 32'd0);

    // 256 completions wrap the tally back to zero
    base_done = done_pulses;
    for (int i = 0; i < 255; i++) push(3'd0);
    wait_done_pulses(base_done, 255, 1000, "wrap_pulses_255");
    check("wrap_count_255", 32'(done_count), 32'd255);
    push(3'd0);
    wait_done_pulses(base_done, 256, 50, "wrap_pulses_256");
    check("wrap_count_0", 32'(done_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
